// File: rtl/spi_slave_byte_pkg.sv
// Shared SPI constants and types for the byte and message layers.
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = 3;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef logic [SPI_BITS-1:0] spi_byte_t;
  typedef logic [CNT_W-1:0]    spi_cnt_t;

endpackage

// File: rtl/spi_slave_byte_if.sv
// SPI pins plus the byte-level handshake toward the message layer.
interface spi_slave_byte_if
  import spi_pkg::*;
();

  logic      SCLK;
  logic      SSEL;
  logic      MOSI;
  logic      MISO;
  logic      rxValid;
  spi_byte_t rx;
  spi_byte_t tx;
  logic      ssActive;

  modport slave (
    input  SCLK, SSEL, MOSI, tx,
    output MISO, rxValid, rx, ssActive
  );

  modport master (
    output SCLK, SSEL, MOSI, tx,
    input  MISO, rxValid, rx, ssActive
  );

endinterface

// File: rtl/spi_slave_byte_sync_edge.sv
// Multi-flop synchroniser with one extra flop for rise/fall strobes.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sysClk,
  input  logic usrReset,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~r_prev;
  assign o_fall = ~o_lvl & r_prev;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave byte engine; MSB first, oversampled in sysClk.
// Define SPI_BYTE_MISO_TRISTATE_EN to float MISO while deselected.
module spi_slave_byte
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = SPI_BITS
) (
  input logic                   sysClk,
  input logic                   usrReset,
  spi_slave_byte_if.slave       spi
);

  logic w_sclkLvl;
  logic w_sclkRiseRaw;
  logic w_sclkFallRaw;
  logic w_sselLvl;
  logic w_ssRise;
  logic w_ssFall;
  logic w_mosiS;
  logic w_ssActive;
  logic w_sclkRise;
  logic w_sclkFall;

  logic [SYNC_STAGES-1:0] r_mosiSync;
  spi_cnt_t               r_bitCnt;
  logic [BITS-1:0]        r_rxShift;
  logic [BITS-1:0]        r_txShift;
  logic [BITS-1:0]        r_rx;
  logic                   r_rxValid;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b0)
  ) u_sclk (
    .sysClk   (sysClk),
    .usrReset (usrReset),
    .i_d      (spi.SCLK),
    .o_lvl    (w_sclkLvl),
    .o_rise   (w_sclkRiseRaw),
    .o_fall   (w_sclkFallRaw)
  );

  // Preset high so a select already low at reset release still yields ssFall
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (1'b1)
  ) u_ssel (
    .sysClk   (sysClk),
    .usrReset (usrReset),
    .i_d      (spi.SSEL),
    .o_lvl    (w_sselLvl),
    .o_rise   (w_ssRise),
    .o_fall   (w_ssFall)
  );

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      r_mosiSync <= '0;
    end else begin
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi.MOSI};
    end
  end

  assign w_mosiS    = r_mosiSync[SYNC_STAGES-1];
  assign w_ssActive = ~w_sselLvl;
  assign w_sclkRise = w_sclkRiseRaw & w_ssActive;
  assign w_sclkFall = w_sclkFallRaw & w_ssActive;

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      r_bitCnt  <= '0;
      r_rxShift <= '0;
      r_txShift <= '0;
      r_rx      <= '0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      unique case (1'b1)
        w_ssRise: begin
          r_bitCnt <= '0;
        end
        w_ssFall: begin
          r_bitCnt  <= '0;
          r_rxShift <= '0;
          r_txShift <= spi.tx;
        end
        w_sclkRise: begin
          r_rxShift <= {r_rxShift[BITS-2:0], w_mosiS};
          r_bitCnt  <= r_bitCnt + spi_cnt_t'(1);
          if (r_bitCnt == spi_cnt_t'(BITS-1)) begin
            r_rx      <= {r_rxShift[BITS-2:0], w_mosiS};
            r_rxValid <= 1'b1;
          end
        end
        w_sclkFall: begin
          // Count back at zero means a byte just finished: fetch the reply
          if (r_bitCnt == '0) begin
            r_txShift <= spi.tx;
          end else begin
            r_txShift <= {r_txShift[BITS-2:0], 1'b0};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign spi.rxValid  = r_rxValid;
  assign spi.rx       = r_rx;
  assign spi.ssActive = w_ssActive;

`ifdef SPI_BYTE_MISO_TRISTATE_EN
  assign spi.MISO = w_ssActive ? r_txShift[BITS-1] : 1'bz;
`else
  assign spi.MISO = w_ssActive & r_txShift[BITS-1];
`endif

  logic w_unused;
  assign w_unused = w_sclkLvl;

endmodule
